// File: rtl/otter_crypto_pkg.sv
// Shared types and constants for the OTTER crypto unit: FSM states, modes,
// round count and the key-schedule helper.
package otter_crypto_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned ROUNDS = 4;
  localparam int unsigned CNT_W  = $clog2(ROUNDS);

  localparam logic [6:0] OP_ENCRY = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cry_state_t;

  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } cry_mode_t;

  // Even rounds use the low key half, odd rounds the high half, each salted with the round index.
  function automatic logic [HALF_W-1:0] round_key(input logic [DATA_W-1:0] key,
                                                  input logic [CNT_W-1:0]  idx);
    logic [HALF_W-1:0] half;
    half = idx[0] ? key[DATA_W-1:HALF_W] : key[HALF_W-1:0];
    return half ^ HALF_W'(idx);
  endfunction

endpackage

// File: rtl/otter_crypto_unit_cry_round.sv
// One Feistel round, combinational. Encrypt consumes R through F, decrypt
// consumes L, so each decrypt round exactly undoes the matching encrypt round.
module cry_round
  import otter_crypto_pkg::*;
#(
  parameter int unsigned ROT_AMT = 3
) (
  input  logic [HALF_W-1:0] l,
  input  logic [HALF_W-1:0] r,
  input  logic [HALF_W-1:0] k,
  input  cry_mode_t         mode,
  output logic [HALF_W-1:0] l_nxt_c,
  output logic [HALF_W-1:0] r_nxt_c
);

  localparam int unsigned ROT = ROT_AMT % HALF_W;

  logic [HALF_W-1:0] f_in_c;
  logic [HALF_W-1:0] rot_c;
  logic [HALF_W-1:0] f_c;

  always_comb begin
    f_in_c = (mode == DEC) ? l : r;
    rot_c  = (f_in_c << ROT) | (f_in_c >> (HALF_W - ROT));
    f_c    = rot_c + k;
    if (mode == DEC) begin
      l_nxt_c = r ^ f_c;
      r_nxt_c = l;
    end else begin
      l_nxt_c = r;
      r_nxt_c = l ^ f_c;
    end
  end

endmodule

// File: rtl/otter_crypto_unit.sv
// OTTER ENCRY execution unit: 4-round 16/16 Feistel cipher, one round per clock,
// sequenced by an IDLE/RUN/DONE FSM that handshakes with the core control FSM.
module otter_crypto_unit
  import otter_crypto_pkg::*;
#(
  parameter int unsigned ROT_AMT = 3
) (
  input  logic              CRY_CLK,
  input  logic              CRY_RESET_N,
  input  logic              CRY_START,
  input  logic              CRY_MODE,
  input  logic [DATA_W-1:0] CRY_DATA,
  input  logic [DATA_W-1:0] CRY_KEY,
  output logic              CRY_BUSY,
  output logic              CRY_DONE,
  output logic [DATA_W-1:0] CRY_RESULT,
  output logic [CNT_W-1:0]  CRY_COUNT
);

  cry_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [HALF_W-1:0] l_q, r_q;
  logic [DATA_W-1:0] key_q;
  cry_mode_t         mode_q;

  logic              load_c;
  logic              step_c;
  logic              last_c;
  logic              busy_d, done_d;
  logic [CNT_W-1:0]  count_d;
  logic [CNT_W-1:0]  rnd_idx_c;
  logic [HALF_W-1:0] rnd_key_c;
  logic [HALF_W-1:0] l_nxt_c, r_nxt_c;

  always_ff @(posedge CRY_CLK or negedge CRY_RESET_N) begin
    if (!CRY_RESET_N) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_c     = 1'b0;
    step_c     = 1'b0;
    last_c     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (CRY_START) begin
          load_c     = 1'b1;
          cnt_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        step_c = 1'b1;
        if (cnt == CNT_W'(ROUNDS - 1)) begin
          last_c     = 1'b1;
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase

    busy_d  = (state_next != ST_IDLE);
    done_d  = (state_next == ST_DONE);
    count_d = (state_next == ST_RUN)  ? cnt_next :
              (state_next == ST_DONE) ? CNT_W'(ROUNDS - 1) : '0;
  end

  // Decrypt walks the key schedule backwards while the counter still counts up.
  always_comb begin
    rnd_idx_c = (mode_q == DEC) ? CNT_W'(ROUNDS - 1) - cnt : cnt;
    rnd_key_c = round_key(key_q, rnd_idx_c);
  end

  cry_round #(
    .ROT_AMT (ROT_AMT)
  ) u_round (
    .l       (l_q),
    .r       (r_q),
    .k       (rnd_key_c),
    .mode    (mode_q),
    .l_nxt_c (l_nxt_c),
    .r_nxt_c (r_nxt_c)
  );

  // Operands only load from IDLE, so a START during RUN cannot disturb them.
  always_ff @(posedge CRY_CLK or negedge CRY_RESET_N) begin
    if (!CRY_RESET_N) begin
      l_q        <= '0;
      r_q        <= '0;
      key_q      <= '0;
      mode_q     <= ENC;
      CRY_RESULT <= '0;
    end else if (load_c) begin
      l_q    <= CRY_DATA[DATA_W-1:HALF_W];
      r_q    <= CRY_DATA[HALF_W-1:0];
      key_q  <= CRY_KEY;
      mode_q <= cry_mode_t'(CRY_MODE);
    end else if (step_c) begin
      l_q <= l_nxt_c;
      r_q <= r_nxt_c;
      if (last_c) begin
        CRY_RESULT <= {l_nxt_c, r_nxt_c};
      end
    end
  end

  always_ff @(posedge CRY_CLK or negedge CRY_RESET_N) begin
    if (!CRY_RESET_N) begin
      CRY_BUSY  <= 1'b0;
      CRY_DONE  <= 1'b0;
      CRY_COUNT <= '0;
    end else begin
      CRY_BUSY  <= busy_d;
      CRY_DONE  <= done_d;
      CRY_COUNT <= count_d;
    end
  end

endmodule

// File: tb/tb_otter_crypto_unit.sv
// Directed self-checking bench for otter_crypto_unit: known vectors, round trip,
// START during RUN, reset mid-operation and back-to-back START.
module tb_otter_crypto_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [31:0] data;
  logic [31:0] key;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  count;

  int vectors;
  int miscompares;

  otter_crypto_unit #(.ROT_AMT(3)) dut (
    .CRY_CLK     (clk),
    .CRY_RESET_N (rst_n),
    .CRY_START   (start),
    .CRY_MODE    (mode),
    .CRY_DATA    (data),
    .CRY_KEY     (key),
    .CRY_BUSY    (busy),
    .CRY_DONE    (done),
    .CRY_RESULT  (result),
    .CRY_COUNT   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference cipher written straight from the round equations.
  function automatic logic [31:0] model(input logic [31:0] d, input logic [31:0] k, input logic dec);
    logic [15:0] l, r, kk, x, f, t;
    int i;
    l = d[31:16];
    r = d[15:0];
    for (int n = 0; n < 4; n++) begin
      i  = dec ? 3 - n : n;
      kk = ((i % 2) == 0) ? k[15:0] : k[31:16];
      kk = kk ^ 16'(i);
      x  = dec ? l : r;
      f  = 16'({x, x} >> 13) + kk;
      if (!dec) begin
        t = l ^ f; l = r; r = t;
      end else begin
        t = r ^ f; r = l; l = t;
      end
    end
    return {l, r};
  endfunction

  // Issues one START and watches 9 cycles; cnts[2p+:2] is CRY_COUNT after edge E+p.
  task automatic run_op(input logic [31:0] d, input logic [31:0] k, input logic m,
                        output logic [31:0] res, output logic [11:0] cnts,
                        output int done_idx, output int ndone);
    data = d; key = k; mode = m; start = 1'b1;
    res = 32'hDEAD_BEEF; cnts = '0; done_idx = -1; ndone = 0;
    for (int p = 0; p < 9; p++) begin
      tick();
      if (p == 0) start = 1'b0;
      if (p < 6) cnts[2*p +: 2] = count;
      if (done) begin
        ndone++;
        done_idx = p;
        res = result;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; data = '0; key = '0;
    #12;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++; if (count !== 2'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
    vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result got=%h exp=00000000", result); end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL first_start_busy got=%b exp=1", busy); end
    repeat (8) tick();
  endtask

  task automatic test_encrypt_zero();
    logic [31:0] res; logic [11:0] cnts; int di, nd;
    logic [11:0] exp_cnts;
    exp_cnts = {2'd0, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    run_op(32'h0, 32'h0, 1'b0, res, cnts, di, nd);
    vectors++; if (res !== 32'h000A0052) begin miscompares++; $display("FAIL enc_zero_result got=%h exp=000a0052", res); end
    vectors++; if (di !== 4) begin miscompares++; $display("FAIL enc_zero_latency got=%0d exp=4", di); end
    vectors++; if (nd !== 1) begin miscompares++; $display("FAIL enc_zero_ndone got=%0d exp=1", nd); end
    vectors++; if (cnts !== exp_cnts) begin miscompares++; $display("FAIL enc_zero_count_seq got=%h exp=%h", cnts, exp_cnts); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL enc_zero_idle_busy got=%b exp=0", busy); end
    vectors++; if (result !== 32'h000A0052) begin miscompares++; $display("FAIL enc_zero_hold got=%h exp=000a0052", result); end
  endtask

  task automatic test_decrypt_vector();
    logic [31:0] res; logic [11:0] cnts; int di, nd;
    run_op(32'h000A0052, 32'h0, 1'b1, res, cnts, di, nd);
    vectors++; if (res !== 32'h0) begin miscompares++; $display("FAIL dec_vec_result got=%h exp=00000000", res); end
    vectors++; if (nd !== 1 || di !== 4) begin miscompares++; $display("FAIL dec_vec_done got=%0d/%0d exp=1/4", nd, di); end
  endtask

  task automatic test_round_trip();
    logic [31:0] res, back, d, k; logic [11:0] cnts, exp_cnts; int di, nd;
    exp_cnts = {2'd0, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    for (int v = 0; v < 4; v++) begin
      d = (v == 0) ? 32'h1234_5678 : (v == 1) ? 32'hFFFF_0001 : 32'($urandom);
      k = (v == 0) ? 32'hA5A5_0F0F : (v == 1) ? 32'h0001_8000 : 32'($urandom);
      run_op(d, k, 1'b0, res, cnts, di, nd);
      vectors++; if (res !== model(d, k, 1'b0)) begin miscompares++; $display("FAIL rt_enc[%0d] got=%h exp=%h", v, res, model(d, k, 1'b0)); end
      vectors++; if (cnts !== exp_cnts) begin miscompares++; $display("FAIL rt_count_seq[%0d] got=%h exp=%h", v, cnts, exp_cnts); end
      run_op(res, k, 1'b1, back, cnts, di, nd);
      vectors++; if (back !== d) begin miscompares++; $display("FAIL rt_dec[%0d] got=%h exp=%h", v, back, d); end
    end
  endtask

  task automatic test_start_in_run();
    logic [31:0] d1, k1; int nd; logic [31:0] res;
    d1 = 32'hCAFE_F00D; k1 = 32'h1357_9BDF;
    data = d1; key = k1; mode = 1'b0; start = 1'b1;
    nd = 0; res = '0;
    for (int p = 0; p < 10; p++) begin
      tick();
      start = (p == 1) ? 1'b1 : 1'b0;
      if (p == 1) begin data = 32'h0BAD_0BAD; key = 32'hFFFF_FFFF; mode = 1'b1; end
      if (done) begin nd++; res = result; end
    end
    vectors++; if (res !== model(d1, k1, 1'b0)) begin miscompares++; $display("FAIL run_start_result got=%h exp=%h", res, model(d1, k1, 1'b0)); end
    vectors++; if (nd !== 1) begin miscompares++; $display("FAIL run_start_ndone got=%0d exp=1", nd); end
    vectors++; if (result !== model(d1, k1, 1'b0)) begin miscompares++; $display("FAIL run_start_hold got=%h exp=%h", result, model(d1, k1, 1'b0)); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] res; logic [11:0] cnts; int di, nd, nd_abort;
    data = 32'h0F0F_F0F0; key = 32'h2222_4444; mode = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    vectors++; if (count !== 2'd2) begin miscompares++; $display("FAIL abort_precount got=%0d exp=2", count); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({busy, done, count} !== 4'b0) begin miscompares++; $display("FAIL abort_ctrl got=%b%b%0d exp=000", busy, done, count); end
    vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL abort_result got=%h exp=00000000", result); end
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    nd_abort = 0;
    for (int p = 0; p < 6; p++) begin
      tick();
      if (done || busy) nd_abort++;
    end
    vectors++; if (nd_abort !== 0) begin miscompares++; $display("FAIL abort_no_done got=%0d exp=0", nd_abort); end
    run_op(32'h0F0F_F0F0, 32'h2222_4444, 1'b0, res, cnts, di, nd);
    vectors++; if (res !== model(32'h0F0F_F0F0, 32'h2222_4444, 1'b0) || di !== 4) begin
      miscompares++; $display("FAIL abort_rerun got=%h@%0d exp=%h@4", res, di, model(32'h0F0F_F0F0, 32'h2222_4444, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    int d0, d1, nd; logic [31:0] r0;
    data = 32'h8000_0001; key = 32'h7FFF_FFFE; mode = 1'b0; start = 1'b1;
    d0 = -1; d1 = -1; nd = 0; r0 = '0;
    for (int p = 0; p < 18; p++) begin
      tick();
      if (p == 11) start = 1'b0;
      if (done) begin
        nd++;
        if (d0 < 0) begin d0 = p; r0 = result; end
        else if (d1 < 0) d1 = p;
      end
    end
    vectors++; if (d0 !== 4 || d1 !== 10) begin miscompares++; $display("FAIL b2b_done_pos got=%0d,%0d exp=4,10", d0, d1); end
    vectors++; if (nd !== 2) begin miscompares++; $display("FAIL b2b_ndone got=%0d exp=2", nd); end
    vectors++; if (r0 !== model(32'h8000_0001, 32'h7FFF_FFFE, 1'b0)) begin
      miscompares++; $display("FAIL b2b_result got=%h exp=%h", r0, model(32'h8000_0001, 32'h7FFF_FFFE, 1'b0));
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_encrypt_zero();
    test_decrypt_vector();
    test_round_trip();
    test_start_in_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
